// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one main-memory port between the I-cache line-fill path and the
// data-memory (LSU) port. A granted fill streams LINE_WORDS sequential word
// reads. A granted data access is a single read or write. At least one idle
// cycle separates transactions, and arbitration happens in that idle cycle.
//
// Ports:
//   CLK, RST_N                     clock, asynchronous active-low reset
//   ic_req/ic_addr                 I-cache fill request (level) and miss address
//   ic_fill_valid/idx/data         per-beat fill return, ic_done on the last beat
//   dm_req/dm_we/dm_addr/dm_wdata  data request (level), held until dm_ack
//   dm_rdata/dm_ack                data completion (rdata is 0 on writes)
//   mem_req/we/addr/wdata          memory request side
//   mem_rdata/mem_ack              memory completion side
//   busy                           high whenever a transaction is in flight
//
// Build option: define DPORT_PRIORITY_EN to give the data port fixed priority
// on a tie. Without it, ties alternate using a last-grant register.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned LINE_WORDS = 8
) (
   input  logic                          CLK,
   input  logic                          RST_N,
   input  logic                          ic_req,
   input  logic [ADDR_W-1:0]             ic_addr,
   output logic                          ic_fill_valid,
   output logic [$clog2(LINE_WORDS)-1:0] ic_fill_idx,
   output logic [DATA_W-1:0]             ic_fill_data,
   output logic                          ic_done,
   input  logic                          dm_req,
   input  logic                          dm_we,
   input  logic [ADDR_W-1:0]             dm_addr,
   input  logic [DATA_W-1:0]             dm_wdata,
   output logic [DATA_W-1:0]             dm_rdata,
   output logic                          dm_ack,
   output logic                          mem_req,
   output logic                          mem_we,
   output logic [ADDR_W-1:0]             mem_addr,
   output logic [DATA_W-1:0]             mem_wdata,
   input  logic [DATA_W-1:0]             mem_rdata,
   input  logic                          mem_ack,
   output logic                          busy
);

   localparam int unsigned BEAT_W = $clog2(LINE_WORDS);
   localparam int unsigned BYTE_W = $clog2(DATA_W / 8);
   localparam int unsigned OFF_W  = BEAT_W + BYTE_W;
   localparam logic [BEAT_W-1:0] LastBeat = BEAT_W'(LINE_WORDS - 1);
   localparam logic [ADDR_W-1:0] OffMask  = ADDR_W'((64'd1 << OFF_W) - 64'd1);

   typedef enum logic [1:0] {StIdle, StIfill, StDacc} state_e;

   state_e              state_q, state_d;
   logic [BEAT_W-1:0]   beat_q, beat_d;
   logic [ADDR_W-1:0]   line_base_q, line_base_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                grant_ic, grant_dm;

`ifdef DPORT_PRIORITY_EN
   // Data port wins every tie; no history needed.
   always_comb begin
      grant_dm = dm_req;
      grant_ic = ic_req & ~dm_req;
   end
`else
   // last_ic_q = 1 when the I-cache held the most recent grant; resets to
   // "data" so the I-cache takes the first tie.
   logic last_ic_q, last_ic_d;

   always_comb begin
      grant_ic = ic_req & (~dm_req | ~last_ic_q);
      grant_dm = dm_req & ~grant_ic;
   end

   always_comb begin
      last_ic_d = last_ic_q;
      if (state_q == StIdle) begin
         if (grant_ic) begin
            last_ic_d = 1'b1;
         end else if (grant_dm) begin
            last_ic_d = 1'b0;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         last_ic_q <= 1'b0;
      end else begin
         last_ic_q <= last_ic_d;
      end
   end
`endif

   // State register
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q     <= StIdle;
         beat_q      <= '0;
         line_base_q <= '0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         beat_q      <= beat_d;
         line_base_q <= line_base_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d     = state_q;
      beat_d      = beat_q;
      line_base_d = line_base_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      unique case (state_q)
         StIdle: begin
            if (grant_ic) begin
               state_d     = StIfill;
               beat_d      = '0;
               line_base_d = ic_addr & ~OffMask;
            end else if (grant_dm) begin
               state_d = StDacc;
               we_d    = dm_we;
               addr_d  = dm_addr;
               wdata_d = dm_wdata;
            end
         end
         StIfill: begin
            if (mem_ack) begin
               // Wraps back to 0 after the last beat of the line.
               beat_d = beat_q + 1'b1;
               if (beat_q == LastBeat) begin
                  state_d = StIdle;
               end
            end
         end
         StDacc: begin
            if (mem_ack) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Output logic; ack-dependent outputs are combinational from mem_ack.
   always_comb begin
      ic_fill_valid = 1'b0;
      ic_fill_idx   = '0;
      ic_fill_data  = '0;
      ic_done       = 1'b0;
      dm_rdata      = '0;
      dm_ack        = 1'b0;
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      mem_addr      = '0;
      mem_wdata     = '0;
      busy          = (state_q != StIdle);
      unique case (state_q)
         StIfill: begin
            mem_req  = 1'b1;
            mem_addr = line_base_q + (ADDR_W'(beat_q) << BYTE_W);
            if (mem_ack) begin
               ic_fill_valid = 1'b1;
               ic_fill_idx   = beat_q;
               ic_fill_data  = mem_rdata;
               ic_done       = (beat_q == LastBeat);
            end
         end
         StDacc: begin
            mem_req   = 1'b1;
            mem_we    = we_q;
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
            if (mem_ack) begin
               dm_ack   = 1'b1;
               dm_rdata = we_q ? '0 : mem_rdata;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a scoreboard queue of expected
// fill beats / data completions, popped by a monitor on the falling edge,
// plus directed per-cycle checks of the memory-side handshake.
module tb_mem_port_arbiter;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic        ic_req;
   logic [31:0] ic_addr;
   logic        ic_fill_valid;
   logic [2:0]  ic_fill_idx;
   logic [31:0] ic_fill_data;
   logic        ic_done;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [31:0] dm_rdata;
   logic        dm_ack;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic        busy;

   always #5 CLK = ~CLK;

   mem_port_arbiter #(
      .ADDR_W     (32),
      .DATA_W     (32),
      .LINE_WORDS (8)
   ) dut (
      .CLK           (CLK),
      .RST_N         (RST_N),
      .ic_req        (ic_req),
      .ic_addr       (ic_addr),
      .ic_fill_valid (ic_fill_valid),
      .ic_fill_idx   (ic_fill_idx),
      .ic_fill_data  (ic_fill_data),
      .ic_done       (ic_done),
      .dm_req        (dm_req),
      .dm_we         (dm_we),
      .dm_addr       (dm_addr),
      .dm_wdata      (dm_wdata),
      .dm_rdata      (dm_rdata),
      .dm_ack        (dm_ack),
      .mem_req       (mem_req),
      .mem_we        (mem_we),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_rdata     (mem_rdata),
      .mem_ack       (mem_ack),
      .busy          (busy)
   );

   // Memory model: acks after mem_delay wait cycles; read data = addr ^ A5A5_0000.
   int unsigned mem_delay;
   logic        spur_ack;
   logic [3:0]  wait_cnt;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wait_cnt <= '0;
      end else if (mem_req && !mem_ack) begin
         wait_cnt <= wait_cnt + 4'd1;
      end else begin
         wait_cnt <= '0;
      end
   end

   always_comb begin
      mem_ack   = spur_ack | (mem_req & (32'(wait_cnt) >= mem_delay));
      mem_rdata = (mem_req && !mem_we) ? (mem_addr ^ 32'hA5A5_0000) : 32'hBAD0_BAD0;
   end

   logic any_out;
   assign any_out = |{ic_fill_valid, ic_fill_idx, ic_fill_data, ic_done, dm_rdata, dm_ack,
                      mem_req, mem_we, mem_addr, mem_wdata, busy};

   typedef struct packed {
      logic        is_dm;
      logic        fv;
      logic [2:0]  idx;
      logic [31:0] data;
      logic        done;
      logic [31:0] addr;
      logic        we;
   } resp_t;

   resp_t sb_q[$];
   int    sb_total = 0, sb_pass = 0;
   int    dir_total = 0, dir_pass = 0;

   // Monitor: every response the DUT presents must match the queue head.
   initial begin
      resp_t got, want;
      forever begin
         @(negedge CLK);
         if (ic_fill_valid || dm_ack || ic_done) begin
            got = '{is_dm: dm_ack, fv: ic_fill_valid, idx: ic_fill_idx,
                    data: dm_ack ? dm_rdata : ic_fill_data, done: ic_done,
                    addr: mem_addr, we: mem_we};
            sb_total++;
            if (sb_q.size() == 0) begin
               $display("FAIL sb_unexpected: got dm=%0d fv=%0d idx=%0d data=%h done=%0d addr=%h, required no response",
                        got.is_dm, got.fv, got.idx, got.data, got.done, got.addr);
            end else begin
               want = sb_q.pop_front();
               if (got === want) begin
                  sb_pass++;
               end else begin
                  $display("FAIL sb_response: got dm=%0d fv=%0d idx=%0d data=%h done=%0d addr=%h we=%0d, required dm=%0d fv=%0d idx=%0d data=%h done=%0d addr=%h we=%0d",
                           got.is_dm, got.fv, got.idx, got.data, got.done, got.addr, got.we,
                           want.is_dm, want.fv, want.idx, want.data, want.done, want.addr, want.we);
               end
            end
         end
      end
   end

   task automatic dcheck(input string name, input logic [63:0] act, input logic [63:0] req);
      dir_total++;
      if (act === req) dir_pass++;
      else $display("FAIL %s: got %h, required %h", name, act, req);
   endtask

   task automatic wait_cycle();
      @(posedge CLK);
      #1;
   endtask

   task automatic push_fill(input logic [31:0] base);
      for (int i = 0; i < 8; i++) begin
         logic [31:0] a;
         resp_t e;
         a = base + 32'(i * 4);
         e = '{is_dm: 1'b0, fv: 1'b1, idx: 3'(i), data: a ^ 32'hA5A5_0000,
               done: (i == 7), addr: a, we: 1'b0};
         sb_q.push_back(e);
      end
   endtask

   task automatic push_dm(input logic we, input logic [31:0] a);
      resp_t e;
      e = '{is_dm: 1'b1, fv: 1'b0, idx: 3'd0, data: we ? 32'h0 : (a ^ 32'hA5A5_0000),
            done: 1'b0, addr: a, we: we};
      sb_q.push_back(e);
   endtask

   task automatic apply_reset();
      RST_N    = 1'b0;
      ic_req   = 1'b0;
      dm_req   = 1'b0;
      spur_ack = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      dcheck("reset_outputs", 64'(any_out), 64'd0);
      @(negedge CLK);
      RST_N = 1'b1;
      wait_cycle();
   endtask

   // Runs until ic_n fills and dm_n data accesses complete, dropping each
   // request once its last completion is seen; checks the idle gap.
   task automatic run_txn(input int ic_n, input int dm_n, input int budget);
      int ic_left = ic_n;
      int dm_left = dm_n;
      int cyc = 0;
      logic was_done = 1'b0;
      while ((ic_left > 0 || dm_left > 0) && cyc < budget) begin
         wait_cycle();
         cyc++;
         if (was_done) dcheck("idle_gap", 64'({busy, mem_req}), 64'd0);
         was_done = ic_done | dm_ack;
         if (ic_done) begin
            ic_left--;
            if (ic_left == 0) ic_req = 1'b0;
         end
         if (dm_ack) begin
            dm_left--;
            if (dm_left == 0) dm_req = 1'b0;
         end
      end
      dcheck("txn_complete", 64'(ic_left == 0 && dm_left == 0), 64'd1);
      ic_req = 1'b0;
      dm_req = 1'b0;
      wait_cycle();
      dcheck("txn_idle_after", 64'({busy, mem_req}), 64'd0);
   endtask

   initial begin
      RST_N     = 1'b0;
      ic_req    = 1'b0;
      ic_addr   = '0;
      dm_req    = 1'b0;
      dm_we     = 1'b0;
      dm_addr   = '0;
      dm_wdata  = '0;
      spur_ack  = 1'b0;
      mem_delay = 0;
      apply_reset();

      // Zero-wait line fill: one beat per cycle, then one idle cycle.
      ic_addr = 32'h0000_1234;
      push_fill(32'h0000_1220);
      ic_req = 1'b1;
      wait_cycle();
      for (int i = 0; i < 8; i++) begin
         dcheck($sformatf("fill_addr%0d", i), 64'({mem_req, mem_addr}),
                64'({1'b1, 32'(32'h1220 + i * 4)}));
         if (i == 7) begin
            dcheck("fill_done_last", 64'(ic_done), 64'd1);
            ic_req = 1'b0;
         end
         wait_cycle();
      end
      dcheck("fill_busy_low", 64'({busy, mem_req}), 64'd0);

      // Data write with 3 wait cycles; inputs change after grant.
      dm_we     = 1'b1;
      dm_addr   = 32'h0000_2000;
      dm_wdata  = 32'hDEAD_BEEF;
      mem_delay = 3;
      push_dm(1'b1, 32'h0000_2000);
      dm_req = 1'b1;
      wait_cycle();
      dm_we    = 1'b0;
      dm_addr  = 32'hFFFF_FFFC;
      dm_wdata = 32'h0;
      for (int c = 0; c < 4; c++) begin
         dcheck($sformatf("dm_cmd%0d", c), 64'({mem_req, mem_we, mem_addr}),
                64'({1'b1, 1'b1, 32'h0000_2000}));
         dcheck($sformatf("dm_wdata%0d", c), 64'(mem_wdata), 64'h0000_0000_DEAD_BEEF);
         dcheck($sformatf("dm_ack%0d", c), 64'(dm_ack), 64'(c == 3));
         if (c == 3) dm_req = 1'b0;
         wait_cycle();
      end
      dcheck("dm_busy_low", 64'({busy, mem_req}), 64'd0);

      // Tie after reset; I-cache keeps requesting a second line.
      mem_delay = 0;
      apply_reset();
      ic_addr  = 32'h0000_4010;
      dm_we    = 1'b0;
      dm_addr  = 32'h0000_3000;
      dm_wdata = 32'h1111_1111;
`ifdef DPORT_PRIORITY_EN
      push_dm(1'b0, 32'h0000_3000);
      push_fill(32'h0000_4000);
      push_fill(32'h0000_4000);
`else
      push_fill(32'h0000_4000);
      push_dm(1'b0, 32'h0000_3000);
      push_fill(32'h0000_4000);
`endif
      ic_req = 1'b1;
      dm_req = 1'b1;
      run_txn(2, 1, 100);

      // Repeated tie: last grant was the I-cache, so data goes first.
      push_dm(1'b0, 32'h0000_3000);
      push_fill(32'h0000_4000);
      ic_req = 1'b1;
      dm_req = 1'b1;
      run_txn(1, 1, 60);

      // Reset on beat 3 of a fill aborts it with no further pulses.
      ic_addr = 32'h0000_1234;
      push_fill(32'h0000_1220);
      void'(sb_q.pop_back());
      void'(sb_q.pop_back());
      void'(sb_q.pop_back());
      void'(sb_q.pop_back());
      void'(sb_q.pop_back());
      ic_req = 1'b1;
      wait_cycle();
      repeat (3) wait_cycle();
      dcheck("abort_beat3_addr", 64'(mem_addr), 64'h0000_0000_0000_122C);
      RST_N  = 1'b0;
      ic_req = 1'b0;
      #1;
      dcheck("abort_outputs", 64'(any_out), 64'd0);
      @(negedge CLK);
      #1;
      dcheck("abort_sb_drained", 64'(sb_q.size()), 64'd0);
      RST_N = 1'b1;
      wait_cycle();
      push_fill(32'h0000_1220);
      ic_req = 1'b1;
      run_txn(1, 0, 40);

      // Spurious ack while idle produces nothing.
      spur_ack = 1'b1;
      for (int k = 0; k < 2; k++) begin
         wait_cycle();
         dcheck($sformatf("spur_quiet%0d", k), 64'({ic_fill_valid, dm_ack, ic_done, busy}), 64'd0);
      end
      spur_ack = 1'b0;

      // Fill at the top of the address space; request dropped after beat 0.
      mem_delay = 1;
      ic_addr   = 32'hFFFF_FFF7;
      push_fill(32'hFFFF_FFE0);
      ic_req = 1'b1;
      wait_cycle();
      wait_cycle();
      wait_cycle();
      ic_req = 1'b0;
      run_txn(1, 0, 60);

      @(negedge CLK);
      #1;
      dcheck("sb_drained", 64'(sb_q.size()), 64'd0);
      $display("%0d/%0d checks passed", dir_pass + sb_pass, dir_total + sb_total);
      $finish;
   end

endmodule
